filter_bank_buffer: RTL and testbench

Multi-filter weight scratchpad. It holds `NUM_FILTERS` independent filters of `DEPTH` words each. A load FSM streams one filter in at a time over a valid/ready port and auto-increments the row. A separate registered random-access port reads rows with one-cycle latency. The block sits between the weight loader and the PE array, and per-filter readiness flags let the controller fetch filter N+1 while filter N is being consumed.

---
 rtl/filter_bank_pkg.sv | 22 ++
 rtl/filter_bank_mem.sv | 50 +++++
 rtl/filter_bank_buffer.sv | 179 +++++++++++++++++
 tb/tb_filter_bank_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_bank_pkg.sv
// Shared types and helpers for the multi-filter weight scratchpad.
package filter_bank_pkg;

  // Load sequencer states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_t;

  // Width of a filter-slot index; a single slot still needs one bit.
  function automatic int fb_fw(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int FB_DEFAULT_FILTERS = 4;
  localparam int FB_DEFAULT_FW      = fb_fw(FB_DEFAULT_FILTERS);

endpackage

// File: rtl/filter_bank_mem.sv
// Simple dual-port 1R1W synchronous RAM backing all filter slots.
// The array itself is never reset; only the read register is.
module filter_bank_mem
  import filter_bank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 48,
  parameter int BYPASS  = 0,
  localparam int MAW    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [MAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rclr,
  input  logic [MAW-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [ENTRIES];
  logic [WIDTH-1:0] rdata_r;

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: zero on request, forwarded write data on a bypassed
  // collision, otherwise the stored (pre-write) word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      if (rclr) begin
        rdata_r <= '0;
      end else if ((BYPASS != 0) && we && (waddr == raddr)) begin
        rdata_r <= wdata;
      end else begin
        rdata_r <= mem_r[raddr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/filter_bank_buffer.sv
// Multi-filter weight scratchpad: streamed per-slot loader, per-slot
// readiness flags and a one-cycle-latency random-access read port.
module filter_bank_buffer
  import filter_bank_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 12,
  parameter int NUM_FILTERS = 4,
  parameter int BYPASS      = 0,
  localparam int AW         = $clog2(DEPTH),
  localparam int FW         = fb_fw(NUM_FILTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [FW-1:0]          load_filter,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  output logic                   load_done,
  input  logic                   rd_en,
  input  logic [FW-1:0]          rd_filter,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   rd_miss,
  input  logic                   inv_en,
  input  logic [FW-1:0]          inv_filter,
  output logic [NUM_FILTERS-1:0] filter_ready
);

  localparam int ENTRIES = NUM_FILTERS * DEPTH;
  localparam int MAW     = $clog2(ENTRIES);

  // Widened constants so range checks stay meaningful at power-of-two sizes.
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
  localparam logic [FW:0]   NF_X     = (FW + 1)'(NUM_FILTERS);

  load_state_t            state_r;
  logic [FW-1:0]          slot_r;
  logic [AW-1:0]          row_r;
  logic                   wr_ready_r;
  logic                   load_done_r;
  logic [NUM_FILTERS-1:0] ready_r;
  logic                   rd_valid_r;
  logic                   rd_miss_r;

  logic                   start_ok_s;
  logic                   inv_slot_s;
  logic                   accept_s;
  logic                   last_s;
  logic                   mem_we_s;
  logic                   complete_s;
  logic [MAW-1:0]         wr_addr_s;
  logic                   rd_oor_s;
  logic                   rd_ready_s;
  logic                   rd_miss_s;
  logic [MAW-1:0]         rd_addr_flat_s;

  assign start_ok_s = load_start && ({1'b0, load_filter} < NF_X);
  assign inv_slot_s = inv_en && (state_r == LOAD) && (inv_filter == slot_r);
  assign accept_s   = wr_valid && wr_ready_r;
  assign last_s     = (row_r == LAST_ROW);
  // An abort drops a mid-load beat, but the final beat still lands.
  assign mem_we_s   = accept_s && (!inv_slot_s || last_s);
  assign complete_s = accept_s && last_s && !inv_slot_s;
  assign wr_addr_s  = MAW'(slot_r) * MAW'(DEPTH) + MAW'(row_r);

  // Read-side range check, readiness lookup and flat address.
  always_comb begin
    rd_oor_s       = ({1'b0, rd_filter} >= NF_X) || ({1'b0, rd_addr} >= DEPTH_X);
    rd_ready_s     = 1'b0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (rd_filter == FW'(i)) begin
        rd_ready_s = ready_r[i];
      end else begin
        rd_ready_s = rd_ready_s;
      end
    end
    rd_miss_s = rd_oor_s || !rd_ready_s;
    if (rd_oor_s) begin
      rd_addr_flat_s = '0;
    end else begin
      rd_addr_flat_s = MAW'(rd_filter) * MAW'(DEPTH) + MAW'(rd_addr);
    end
  end

  // Load sequencer: slot latch, row counter, wr_ready and load_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      slot_r      <= '0;
      row_r       <= '0;
      wr_ready_r  <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      load_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            slot_r     <= load_filter;
            row_r      <= '0;
            state_r    <= LOAD;
            wr_ready_r <= 1'b1;
          end
        end
        LOAD: begin
          if (inv_slot_s) begin
            state_r    <= IDLE;
            wr_ready_r <= 1'b0;
          end else if (accept_s) begin
            row_r <= row_r + AW'(1);
            if (last_s) begin
              state_r     <= IDLE;
              wr_ready_r  <= 1'b0;
              load_done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          wr_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Per-slot readiness: invalidate beats a new load, which beats completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= '0;
    end else begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if (inv_en && (inv_filter == FW'(i))) begin
          ready_r[i] <= 1'b0;
        end else if ((state_r == IDLE) && start_ok_s && (load_filter == FW'(i))) begin
          ready_r[i] <= 1'b0;
        end else if (complete_s && (slot_r == FW'(i))) begin
          ready_r[i] <= 1'b1;
        end
      end
    end
  end

  // Read status pipeline alongside the RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_miss_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      rd_miss_r  <= rd_en && rd_miss_s;
    end
  end

  filter_bank_mem #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .BYPASS  (BYPASS)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .waddr (wr_addr_s),
    .wdata (wr_data),
    .re    (rd_en),
    .rclr  (rd_oor_s),
    .raddr (rd_addr_flat_s),
    .rdata (rd_data)
  );

  assign wr_ready     = wr_ready_r;
  assign load_done    = load_done_r;
  assign rd_valid     = rd_valid_r;
  assign rd_miss      = rd_miss_r;
  assign filter_ready = ready_r;

endmodule

// File: tb/tb_filter_bank_buffer.sv
// Directed bench for filter_bank_buffer; two instances (BYPASS 0 and 1)
// share all inputs so the collision policy of both is checked together.
module tb_filter_bank_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 12;
  localparam int NF    = 4;
  localparam int AW    = 4;
  localparam int FW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_start;
  logic [FW-1:0]    load_filter;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [FW-1:0]    rd_filter;
  logic [AW-1:0]    rd_addr;
  logic             inv_en;
  logic [FW-1:0]    inv_filter;

  logic             wr_ready0, load_done0, rd_valid0, rd_miss0;
  logic [WIDTH-1:0] rd_data0;
  logic [NF-1:0]    filter_ready0;
  logic             wr_ready1, load_done1, rd_valid1, rd_miss1;
  logic [WIDTH-1:0] rd_data1;
  logic [NF-1:0]    filter_ready1;

  int errors = 0;
  int checks = 0;
  int done_cnt;

  typedef struct {
    logic [FW-1:0]    f;
    logic [AW-1:0]    a;
    logic             chk_data;
    logic [WIDTH-1:0] exp_data;
    logic             exp_miss;
  } rd_vec_t;

  rd_vec_t vecs [16];

  always #5 clk = ~clk;

  filter_bank_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FILTERS(NF), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_filter(load_filter),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready0), .load_done(load_done0),
    .rd_en(rd_en), .rd_filter(rd_filter), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .rd_miss(rd_miss0), .inv_en(inv_en), .inv_filter(inv_filter),
    .filter_ready(filter_ready0)
  );

  filter_bank_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FILTERS(NF), .BYPASS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_filter(load_filter),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready1), .load_done(load_done1),
    .rd_en(rd_en), .rd_filter(rd_filter), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .rd_miss(rd_miss1), .inv_en(inv_en), .inv_filter(inv_filter),
    .filter_ready(filter_ready1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_start  = 1'b0;
    load_filter = '0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    rd_en       = 1'b0;
    rd_filter   = '0;
    rd_addr     = '0;
    inv_en      = 1'b0;
    inv_filter  = '0;
  endtask

  task automatic start_load(input logic [FW-1:0] f);
    load_start  = 1'b1;
    load_filter = f;
    step();
    load_start  = 1'b0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [FW-1:0] f, input logic [AW-1:0] a,
                          input logic chk_data, input logic [WIDTH-1:0] exp_data,
                          input logic exp_miss);
    rd_en     = 1'b1;
    rd_filter = f;
    rd_addr   = a;
    step();
    rd_en     = 1'b0;
    chk({name, "_valid"}, {31'd0, rd_valid0}, {31'd0, 1'b1});
    chk({name, "_miss"}, {31'd0, rd_miss0}, {31'd0, exp_miss});
    if (chk_data) begin
      chk({name, "_data"}, {16'd0, rd_data0}, {16'd0, exp_data});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // Read vector table: filter 2 fully loaded, plus miss cases.
    for (int i = 0; i < DEPTH; i++) begin
      vecs[i].f        = 2'd2;
      vecs[i].a        = AW'(i);
      vecs[i].chk_data = 1'b1;
      vecs[i].exp_data = 16'h0100 + 16'(i);
      vecs[i].exp_miss = 1'b0;
    end
    vecs[12] = '{f: 2'd0, a: 4'd0,  chk_data: 1'b0, exp_data: 16'h0000, exp_miss: 1'b1};
    vecs[13] = '{f: 2'd2, a: 4'd12, chk_data: 1'b1, exp_data: 16'h0000, exp_miss: 1'b1};
    vecs[14] = '{f: 2'd2, a: 4'd15, chk_data: 1'b1, exp_data: 16'h0000, exp_miss: 1'b1};
    vecs[15] = '{f: 2'd3, a: 4'd0,  chk_data: 1'b0, exp_data: 16'h0000, exp_miss: 1'b1};

    // Reset values.
    idle_inputs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_wr_ready", {31'd0, wr_ready0}, 32'd0);
    chk("rst_load_done", {31'd0, load_done0}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid0}, 32'd0);
    chk("rst_rd_miss", {31'd0, rd_miss0}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data0}, 32'd0);
    chk("rst_filter_ready", {28'd0, filter_ready0}, 32'd0);
    rst_n = 1'b1;
    step();
    rd_check("rst_read", 2'd0, 4'd0, 1'b0, 16'h0000, 1'b1);
    chk("rst_read_ready", {28'd0, filter_ready0}, 32'd0);

    // Gapped load of filter 2.
    load_start  = 1'b1;
    load_filter = 2'd2;
    chk("idle_wr_ready", {31'd0, wr_ready0}, 32'd0);
    step();
    load_start = 1'b0;
    chk("load_wr_ready", {31'd0, wr_ready0}, 32'd1);
    done_cnt = 0;
    for (int b = 0; b < DEPTH; b++) begin
      wr_valid = 1'b0;
      step();
      chk("gap_wr_ready", {31'd0, wr_ready0}, 32'd1);
      if (load_done0) done_cnt++;
      beat(16'h0100 + 16'(b));
      if (load_done0) done_cnt++;
    end
    chk("f2_done_pulse", {31'd0, load_done0}, 32'd1);
    chk("f2_wr_ready_off", {31'd0, wr_ready0}, 32'd0);
    chk("f2_ready", {28'd0, filter_ready0}, 32'h4);
    step();
    chk("f2_done_once", done_cnt, 32'd1);
    chk("f2_done_clear", {31'd0, load_done0}, 32'd0);

    // Table-driven back-to-back reads.
    for (int v = 0; v < 16; v++) begin
      rd_en     = 1'b1;
      rd_filter = vecs[v].f;
      rd_addr   = vecs[v].a;
      step();
      chk("tbl_valid", {31'd0, rd_valid0}, 32'd1);
      chk("tbl_miss", {31'd0, rd_miss0}, {31'd0, vecs[v].exp_miss});
      if (vecs[v].chk_data) begin
        chk("tbl_data0", {16'd0, rd_data0}, {16'd0, vecs[v].exp_data});
        chk("tbl_data1", {16'd0, rd_data1}, {16'd0, vecs[v].exp_data});
      end
    end
    rd_en = 1'b0;
    step();
    chk("tbl_valid_off", {31'd0, rd_valid0}, 32'd0);

    // Load filter 3 while consuming filter 2 every cycle.
    start_load(2'd3);
    for (int b = 0; b < DEPTH; b++) begin
      wr_valid  = 1'b1;
      wr_data   = (b == 5) ? 16'hAAAA : 16'h0300 + 16'(b);
      rd_en     = 1'b1;
      rd_filter = 2'd2;
      rd_addr   = AW'(b);
      step();
      chk("ovl_miss", {31'd0, rd_miss0}, 32'd0);
      chk("ovl_data", {16'd0, rd_data0}, {16'd0, 16'h0100 + 16'(b)});
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk("f3_done", {31'd0, load_done0}, 32'd1);
    chk("f3_ready", {28'd0, filter_ready0}, 32'hC);

    // Same-cycle read/write collision on filter 3 row 5.
    start_load(2'd3);
    chk("reload_clears", {28'd0, filter_ready0}, 32'h4);
    for (int b = 0; b < 5; b++) beat(16'h3100 + 16'(b));
    wr_valid  = 1'b1;
    wr_data   = 16'hBEEF;
    rd_en     = 1'b1;
    rd_filter = 2'd3;
    rd_addr   = 4'd5;
    step();
    wr_valid = 1'b0;
    chk("col_bypass0", {16'd0, rd_data0}, 32'hAAAA);
    chk("col_bypass1", {16'd0, rd_data1}, 32'hBEEF);
    chk("col_miss", {31'd0, rd_miss0}, 32'd1);
    step();
    rd_en = 1'b0;
    chk("col_reread0", {16'd0, rd_data0}, 32'hBEEF);
    chk("col_reread1", {16'd0, rd_data1}, 32'hBEEF);
    for (int b = 6; b < DEPTH; b++) beat(16'h3100 + 16'(b));
    chk("f3b_done", {31'd0, load_done0}, 32'd1);
    chk("f3b_ready", {28'd0, filter_ready0}, 32'hC);

    // Invalidate filter 1 mid-load; a start during LOAD is ignored.
    start_load(2'd1);
    for (int b = 0; b < DEPTH; b++) beat(16'h1100 + 16'(b));
    chk("f1_ready", {28'd0, filter_ready0}, 32'hE);
    start_load(2'd1);
    for (int b = 0; b < 6; b++) beat(16'h1200 + 16'(b));
    load_start  = 1'b1;
    load_filter = 2'd1;
    step();
    load_start = 1'b0;
    chk("ign_start_wr_ready", {31'd0, wr_ready0}, 32'd1);
    beat(16'h1206);
    wr_valid   = 1'b1;
    wr_data    = 16'hDEAD;
    inv_en     = 1'b1;
    inv_filter = 2'd1;
    step();
    inv_en   = 1'b0;
    wr_valid = 1'b0;
    chk("inv_wr_ready", {31'd0, wr_ready0}, 32'd0);
    chk("inv_no_done", {31'd0, load_done0}, 32'd0);
    chk("inv_ready", {28'd0, filter_ready0}, 32'hC);
    beat(16'h5555);
    chk("idle_beat_wr_ready", {31'd0, wr_ready0}, 32'd0);
    chk("idle_beat_no_done", {31'd0, load_done0}, 32'd0);
    rd_check("inv_row0", 2'd1, 4'd0, 1'b1, 16'h1200, 1'b1);
    rd_check("inv_row5", 2'd1, 4'd5, 1'b1, 16'h1205, 1'b1);
    rd_check("inv_row6", 2'd1, 4'd6, 1'b1, 16'h1206, 1'b1);
    rd_check("inv_row7", 2'd1, 4'd7, 1'b1, 16'h1107, 1'b1);

    // Reset asserted mid-load of filter 0.
    start_load(2'd0);
    for (int b = 0; b < 2; b++) beat(16'h0A00 + 16'(b));
    wr_valid  = 1'b1;
    wr_data   = 16'h0A02;
    rd_en     = 1'b1;
    rd_filter = 2'd2;
    rd_addr   = 4'd1;
    step();
    idle_inputs();
    chk("pre_rst_data", {16'd0, rd_data0}, 32'h0101);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_ready", {31'd0, wr_ready0}, 32'd0);
    chk("mid_rst_rd_valid", {31'd0, rd_valid0}, 32'd0);
    chk("mid_rst_rd_data", {16'd0, rd_data0}, 32'd0);
    chk("mid_rst_ready", {28'd0, filter_ready0}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_no_done", {31'd0, load_done0}, 32'd0);
    chk("post_rst_wr_ready", {31'd0, wr_ready0}, 32'd0);
    rd_check("post_rst_read", 2'd0, 4'd0, 1'b0, 16'h0000, 1'b1);

    // Invalidate coinciding with the final beat of the same slot.
    start_load(2'd0);
    for (int b = 0; b < DEPTH - 1; b++) beat(16'h0B00 + 16'(b));
    wr_valid   = 1'b1;
    wr_data    = 16'h0B0B;
    inv_en     = 1'b1;
    inv_filter = 2'd0;
    step();
    inv_en   = 1'b0;
    wr_valid = 1'b0;
    chk("inv_last_no_done", {31'd0, load_done0}, 32'd0);
    chk("inv_last_wr_ready", {31'd0, wr_ready0}, 32'd0);
    chk("inv_last_ready", {28'd0, filter_ready0}, 32'd0);
    rd_check("inv_last_row11", 2'd0, 4'd11, 1'b1, 16'h0B0B, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
